// File: rtl/led_pattern_ctrl.sv
// Plays an 8-slot LED pattern (one ctrl bit per slot, each slot time_set cycles long), repeating per period.
// Pattern and slot length are captured only at period boundaries; time_set==0 returns to idle after the period.
module led_pattern_ctrl #(
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [7:0]  ctrl,
    input  logic [31:0] time_set,
    output logic        led,
    output logic [2:0]  slot,
    output logic        period_done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [31:0] cnt;
    logic [31:0] time_sh;
    logic [7:0]  ctrl_sh;
    logic        slot_end;
    logic [2:0]  slot_nxt;

    // time_sh is never zero while in RUN, so the subtraction cannot wrap there
    assign slot_end = (cnt == time_sh - 32'd1);
    assign slot_nxt = slot + 3'd1;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= IDLE;
            cnt         <= '0;
            slot        <= '0;
            ctrl_sh     <= '0;
            time_sh     <= '0;
            led         <= IDLE_LEVEL;
            period_done <= 1'b0;
        end else begin
            period_done <= 1'b0;
            case (state)
                IDLE: begin
                    cnt  <= '0;
                    slot <= '0;
                    if (time_set != 32'd0) begin
                        state   <= RUN;
                        ctrl_sh <= ctrl;
                        time_sh <= time_set;
                        led     <= ctrl[0];
                    end else begin
                        led <= IDLE_LEVEL;
                    end
                end
                RUN: begin
                    if (!slot_end) begin
                        cnt <= cnt + 32'd1;
                    end else if (slot != 3'd7) begin
                        cnt  <= '0;
                        slot <= slot_nxt;
                        led  <= ctrl_sh[slot_nxt];
                    end else begin
                        // period end: take the new command, or fall back to idle
                        period_done <= 1'b1;
                        cnt         <= '0;
                        slot        <= '0;
                        ctrl_sh     <= ctrl;
                        time_sh     <= time_set;
                        if (time_set != 32'd0) begin
                            led <= ctrl[0];
                        end else begin
                            state <= IDLE;
                            led   <= IDLE_LEVEL;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed table and sequences plus random traffic checked each cycle
// against a period-position model (slot = position / length, led = pattern[slot]).
module tb_led_pattern_ctrl;

    localparam logic IDL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  ctrl = 8'h00;
    logic [31:0] time_set = 32'd0;
    logic        led;
    logic [2:0]  slot;
    logic        period_done;

    led_pattern_ctrl #(.IDLE_LEVEL(IDL)) dut (
        .Clk        (clk),
        .Reset_n    (rst_n),
        .ctrl       (ctrl),
        .time_set   (time_set),
        .led        (led),
        .slot       (slot),
        .period_done(period_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    bit chk_en = 1'b1;

    // reference model: running flag, captured pattern/length, position within the period
    bit              m_run = 1'b0;
    bit              m_pd = 1'b0;
    logic [7:0]      m_pat = 8'h00;
    logic [31:0]     m_len = 32'd0;
    longint unsigned m_pos = 0;

    typedef struct {
        int          e;
        logic [7:0]  c;
        logic [31:0] ts;
        logic        x_led;
        logic [2:0]  x_slot;
        logic        x_pd;
    } vec_t;
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_run = 1'b0;
                m_pd  = 1'b0;
            end else if (!m_run) begin
                m_pd = 1'b0;
                if (time_set != 32'd0) begin
                    m_run = 1'b1;
                    m_pat = ctrl;
                    m_len = time_set;
                    m_pos = 0;
                end
            end else begin
                m_pd  = 1'b0;
                m_pos = m_pos + 1;
                if (m_pos == 64'(m_len) * 8) begin
                    m_pd  = 1'b1;
                    m_pat = ctrl;
                    m_len = time_set;
                    m_pos = 0;
                    if (time_set == 32'd0) m_run = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [2:0] es;
        logic       el;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                if (m_run) begin
                    es = 3'(m_pos / 64'(m_len));
                    el = m_pat[es];
                end else begin
                    es = 3'd0;
                    el = IDL;
                end
                check("model_led", 32'(led), 32'(el));
                check("model_slot", 32'(slot), 32'(es));
                check("model_pd", 32'(period_done), 32'(m_pd));
            end
        end
    end

    task automatic step_to(input int e);
        while (edge_n < e) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    task automatic restart(input logic [7:0] c, input logic [31:0] ts);
        @(negedge clk);
        rst_n = 1'b0;
        ctrl = c;
        time_set = ts;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        edge_n = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        tbl.push_back('{1,  8'hA5, 32'd4, 1'b1, 3'd0, 1'b0});
        tbl.push_back('{4,  8'hA5, 32'd4, 1'b1, 3'd0, 1'b0});
        tbl.push_back('{5,  8'hA5, 32'd4, 1'b0, 3'd1, 1'b0});
        tbl.push_back('{9,  8'hA5, 32'd4, 1'b1, 3'd2, 1'b0});
        tbl.push_back('{13, 8'h0F, 32'd4, 1'b0, 3'd3, 1'b0});
        tbl.push_back('{17, 8'h0F, 32'd4, 1'b0, 3'd4, 1'b0});
        tbl.push_back('{21, 8'h0F, 32'd4, 1'b1, 3'd5, 1'b0});
        tbl.push_back('{25, 8'h0F, 32'd4, 1'b0, 3'd6, 1'b0});
        tbl.push_back('{29, 8'h0F, 32'd4, 1'b1, 3'd7, 1'b0});
        tbl.push_back('{32, 8'h0F, 32'd4, 1'b1, 3'd7, 1'b0});
        tbl.push_back('{33, 8'h0F, 32'd4, 1'b1, 3'd0, 1'b1});
        tbl.push_back('{34, 8'h0F, 32'd4, 1'b1, 3'd0, 1'b0});
        tbl.push_back('{37, 8'h0F, 32'd4, 1'b1, 3'd1, 1'b0});
        tbl.push_back('{41, 8'h0F, 32'd4, 1'b1, 3'd2, 1'b0});
        tbl.push_back('{45, 8'h0F, 32'd2, 1'b1, 3'd3, 1'b0});
        tbl.push_back('{48, 8'h0F, 32'd2, 1'b1, 3'd3, 1'b0});
        tbl.push_back('{49, 8'h0F, 32'd2, 1'b0, 3'd4, 1'b0});
        tbl.push_back('{53, 8'h0F, 32'd2, 1'b0, 3'd5, 1'b0});
        tbl.push_back('{57, 8'h0F, 32'd2, 1'b0, 3'd6, 1'b0});
        tbl.push_back('{64, 8'h0F, 32'd2, 1'b0, 3'd7, 1'b0});
        tbl.push_back('{65, 8'h0F, 32'd2, 1'b1, 3'd0, 1'b1});
        tbl.push_back('{67, 8'h0F, 32'd2, 1'b1, 3'd1, 1'b0});
        tbl.push_back('{73, 8'h0F, 32'd2, 1'b0, 3'd4, 1'b0});
        tbl.push_back('{80, 8'h0F, 32'd2, 1'b0, 3'd7, 1'b0});
        tbl.push_back('{81, 8'h0F, 32'd2, 1'b1, 3'd0, 1'b1});

        // reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_led", 32'(led), 32'(IDL));
        check("rst_slot", 32'(slot), 32'd0);
        check("rst_pd", 32'(period_done), 32'd0);

        // A5 pattern, mid-period ctrl change, mid-period length change
        restart(8'hA5, 32'd4);
        foreach (tbl[i]) begin
            step_to(tbl[i].e);
            check($sformatf("tbl%0d_led", tbl[i].e), 32'(led), 32'(tbl[i].x_led));
            check($sformatf("tbl%0d_slot", tbl[i].e), 32'(slot), 32'(tbl[i].x_slot));
            check($sformatf("tbl%0d_pd", tbl[i].e), 32'(period_done), 32'(tbl[i].x_pd));
            ctrl = tbl[i].c;
            time_set = tbl[i].ts;
        end

        // stop request mid-period: current period completes, then idle
        restart(8'h24, 32'd3);
        step_to(5);
        time_set = 32'd0;
        step_to(10);
        check("stop_slot_mid", 32'(slot), 32'd3);
        step_to(24);
        check("stop_last_slot", 32'(slot), 32'd7);
        check("stop_last_pd", 32'(period_done), 32'd0);
        step_to(25);
        check("stop_pd", 32'(period_done), 32'd1);
        check("stop_led_idle", 32'(led), 32'(IDL));
        check("stop_slot0", 32'(slot), 32'd0);
        step_to(30);
        check("idle_pd", 32'(period_done), 32'd0);
        check("idle_led", 32'(led), 32'(IDL));
        check("idle_cnt", dut.cnt, 32'd0);

        // one-cycle slots
        restart(8'h01, 32'd1);
        for (int k = 1; k <= 40; k++) begin
            step_to(k);
            check($sformatf("fast%0d_slot", k), 32'(slot), 32'((k - 1) % 8));
            check($sformatf("fast%0d_led", k), 32'(led), 32'(((k - 1) % 8) == 0));
            check($sformatf("fast%0d_pd", k), 32'(period_done), 32'((k > 1) && (((k - 1) % 8) == 0)));
        end

        // asynchronous reset mid-period
        restart(8'h5A, 32'd10);
        step_to(53);
        check("ares_pre_slot", 32'(slot), 32'd5);
        #1 rst_n = 1'b0;
        #1;
        check("ares_led", 32'(led), 32'(IDL));
        check("ares_slot", 32'(slot), 32'd0);
        check("ares_pd", 32'(period_done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("ares_hold_pd", 32'(period_done), 32'd0);
        end
        rst_n = 1'b1;
        edge_n = 0;
        step_to(1);
        check("ares_rel_led", 32'(led), 32'd0);
        check("ares_rel_slot", 32'(slot), 32'd0);
        step_to(11);
        check("ares_rel_slot1", 32'(slot), 32'd1);
        check("ares_rel_led1", 32'(led), 32'd1);

        // random traffic against the model
        restart(8'($urandom), 32'($urandom_range(1, 5)));
        for (int k = 0; k < 400; k++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 3) == 0) ctrl = 8'($urandom);
            if ($urandom_range(0, 11) == 0) time_set = 32'($urandom_range(0, 5));
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end

        // maximum slot length, counter pushed near its terminal value
        restart(8'h02, 32'hFFFF_FFFF);
        step_to(50);
        check("max_slot_early", 32'(slot), 32'd0);
        check("max_led_early", 32'(led), 32'd0);
        chk_en = 1'b0;
        force dut.cnt = 32'hFFFF_FFFC;
        #1 release dut.cnt;
        step_to(51);
        check("max_cnt_fd", dut.cnt, 32'hFFFF_FFFD);
        check("max_slot_fd", 32'(slot), 32'd0);
        step_to(52);
        check("max_slot_fe", 32'(slot), 32'd0);
        check("max_led_fe", 32'(led), 32'd0);
        step_to(53);
        check("max_slot_wrap", 32'(slot), 32'd1);
        check("max_led_wrap", 32'(led), 32'd1);
        check("max_cnt_wrap", dut.cnt, 32'd0);
        check("max_pd_wrap", 32'(period_done), 32'd0);
        step_to(54);
        check("max_slot_hold", 32'(slot), 32'd1);
        check("max_cnt_inc", dut.cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
